// File: rtl/opram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM control pins.
// With OPRAM_ARB_LOCK_EN defined, the bundle also carries the a_lock and b_lock lines.
interface opram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;

`ifdef OPRAM_ARB_LOCK_EN
    logic          a_lock;
    logic          b_lock;
`endif

    logic          ram_ce;
    logic          ram_oce;
    logic          ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    // Arbiter side
    modport slave (
`ifdef OPRAM_ARB_LOCK_EN
        input  a_lock, b_lock,
`endif
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_dout,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_ce, ram_oce, ram_wre, ram_ad, ram_din
    );

    // Requester / RAM side
    modport master (
`ifdef OPRAM_ARB_LOCK_EN
        output a_lock, b_lock,
`endif
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_dout,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_ce, ram_oce, ram_wre, ram_ad, ram_din
    );
endinterface

// File: rtl/opram_arbiter.sv
// Round-robin arbiter that shares one single-port op-code RAM between ports A and B.
// Defining OPRAM_ARB_LOCK_EN adds per-port lock, which gives one port exclusive ownership.
module opram_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    opram_arbiter_if.slave bus
);
    logic          w_rr_a;
    logic          w_rr_b;
    logic          w_sel_a;
    logic          w_sel_b;
    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_gnt;
    logic          w_we;
    logic [AW-1:0] w_ad;
    logic [DW-1:0] w_din;
    logic          r_last_b;
    logic          r_oce;

    // On contention the port that was not granted last wins.
    always_comb begin
        w_rr_a = bus.a_req && (!bus.b_req || r_last_b);
        w_rr_b = bus.b_req && !w_rr_a;
    end

`ifdef OPRAM_ARB_LOCK_EN
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_t;
    own_t r_own;
    own_t w_own_next;
    logic w_owned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_own <= OWN_NONE;
        else       r_own <= w_own_next;
    end

    always_comb begin
        w_owned = ((r_own == OWN_A) && bus.a_req && bus.a_lock) ||
                  ((r_own == OWN_B) && bus.b_req && bus.b_lock);
        w_sel_a = w_rr_a;
        w_sel_b = w_rr_b;
        if (w_owned) begin
            w_sel_a = (r_own == OWN_A);
            w_sel_b = (r_own == OWN_B);
        end
        // Ownership survives only while the owner keeps winning with lock high.
        w_own_next = OWN_NONE;
        if (w_gnt_a && bus.a_lock)      w_own_next = OWN_A;
        else if (w_gnt_b && bus.b_lock) w_own_next = OWN_B;
    end
`else
    always_comb begin
        w_sel_a = w_rr_a;
        w_sel_b = w_rr_b;
    end
`endif

    assign w_gnt_a = w_sel_a && !reset;
    assign w_gnt_b = w_sel_b && !reset;
    assign w_gnt   = w_gnt_a || w_gnt_b;

    always_comb begin
        w_we  = 1'b0;
        w_ad  = '0;
        w_din = '0;
        if (w_gnt_a) begin
            w_we  = bus.a_we;
            w_ad  = bus.a_addr;
            w_din = bus.a_wdata;
        end else if (w_gnt_b) begin
            w_we  = bus.b_we;
            w_ad  = bus.b_addr;
            w_din = bus.b_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_b <= 1'b1;
            r_oce    <= 1'b0;
        end else begin
            r_oce <= 1'b1;
            if (w_gnt_a)      r_last_b <= 1'b0;
            else if (w_gnt_b) r_last_b <= 1'b1;
        end
    end

    // Read tags travel alongside the RAM read pipeline, one stage per clock of latency.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            logic r_vld;
            logic r_b;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_vld <= 1'b0;
                        r_b   <= 1'b0;
                    end else begin
                        r_vld <= w_gnt && !w_we;
                        r_b   <= w_gnt_b;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_vld <= 1'b0;
                        r_b   <= 1'b0;
                    end else begin
                        r_vld <= g_tag[gi-1].r_vld;
                        r_b   <= g_tag[gi-1].r_b;
                    end
                end
            end
        end
    endgenerate

    assign bus.a_gnt    = w_gnt_a;
    assign bus.b_gnt    = w_gnt_b;
    assign bus.a_rvalid = g_tag[RD_LAT-1].r_vld && !g_tag[RD_LAT-1].r_b;
    assign bus.b_rvalid = g_tag[RD_LAT-1].r_vld &&  g_tag[RD_LAT-1].r_b;
    assign bus.a_rdata  = bus.ram_dout;
    assign bus.b_rdata  = bus.ram_dout;
    assign bus.ram_ce   = w_gnt;
    assign bus.ram_wre  = w_we;
    assign bus.ram_ad   = w_ad;
    assign bus.ram_din  = w_din;
    assign bus.ram_oce  = r_oce;
endmodule
